conv_output_scheduler: RTL and testbench
========================================

CONV_OUTPUT_SCHEDULER -- requirements
Module: conv_output_scheduler

Interface
REQ-001 Parameter DATA_W, default 64: stream data width in bits; a multiple of 8.
REQ-002 Parameter TIMEOUT, default 65535: maximum DRAIN cycles allowed while waiting for dp_last.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 cfg_valid  in  1  layer descriptor valid.
REQ-006 cfg_ready  out  1  descriptor accepted when cfg_valid and cfg_ready are both high.
REQ-007 cfg_in_channel  in  16  input channel count.
REQ-008 cfg_matrix_col  in  8  matrix columns.
REQ-009 cfg_matrix_row  in  8  matrix rows.
REQ-010 s_valid / s_ready / s_data  in / out / DATA_W  upstream activation stream.
REQ-011 dp_valid / dp_ready / dp_data  out / in / DATA_W  stream into the conv-output datapath.
REQ-012 dp_start  out  1  one-cycle start pulse to the datapath.
REQ-013 dp_in_channel / dp_matrix_col / dp_matrix_row  out  16/8/8  latched layer configuration.
REQ-014 dp_last  in  1  datapath final output beat accepted.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 layer_done  out  1  one-cycle completion pulse.
REQ-017 timeout_err  out  1  sticky error flag; cleared on the next descriptor accept.

Function
REQ-018 The FSM SHALL have states IDLE, ARM, STREAM, DRAIN and DONE.
REQ-019 IDLE: cfg_ready=1. On accept, latch the configuration into the dp_* config outputs, clear timeout_err, and compute total_beats = ceil(in_channel*col*row / (DATA_W/8)). The product is 32 bits and the beat counter is 32 bits.
REQ-020 If total_beats==0 on accept, the FSM SHALL go to DONE with no dp_start and no beats transferred.
REQ-021 Otherwise the FSM SHALL go to ARM. ARM drives dp_start=1 for exactly one cycle and then moves to STREAM.
REQ-022 Latency: descriptor accepted in cycle T -> dp_start in cycle T+1 -> first dp beat possible in cycle T+2.
REQ-023 STREAM: dp_valid=s_valid, s_ready=dp_ready, dp_data=s_data, all combinational with zero latency.
- Beat counter increments on dp_valid & dp_ready.
- Acceptance of beat total_beats-1 moves the FSM to DRAIN.
REQ-024 Outside STREAM: s_ready=0, dp_valid=0, dp_data=0.
REQ-025 dp_last seen in STREAM or ARM SHALL set a seen-flag. DRAIN with the flag set exits to DONE on the next cycle.
REQ-026 DRAIN: a timeout counter increments every cycle.
- dp_last moves the FSM to DONE.
- Counter reaching TIMEOUT sets timeout_err=1 and moves the FSM to DONE.
- If dp_last and TIMEOUT occur in the same cycle, dp_last wins and timeout_err is not set.
REQ-027 DONE: layer_done=1 for one cycle, then the FSM returns to IDLE.
REQ-028 dp_in_channel, dp_matrix_col and dp_matrix_row SHALL hold their values until the next descriptor accept.
REQ-029 cfg_valid asserted while not in IDLE SHALL be ignored; cfg_ready stays 0.

Reset
REQ-030 While reset=0, on each rising clk:
- state=IDLE;
- all counters, flags and outputs=0, including cfg_ready=0;
- cfg_ready=1 from the first cycle after release.
REQ-031 Reset asserted mid-operation SHALL abort the layer: no layer_done, no timeout_err, no further dp beats.

Verification
REQ-032 Nominal layer: cfg 32/14/14, DATA_W=64 -> dp_start 1 cycle after accept; exactly 784 beats forwarded in order; dp_last -> layer_done for 1 cycle; busy low afterwards.
REQ-033 Backpressure: dp_ready random 50%, s_valid random 70% -> s_ready mirrors dp_ready; data sequence identical; no beat lost or duplicated; count stays 784.
REQ-034 Zero size: cfg 32/0/14 -> no dp_start; layer_done 2 cycles after accept.
REQ-035 Ceiling and timeout: TIMEOUT=100, cfg 3/1/1 -> 1 beat forwarded; dp_last never asserted -> timeout_err=1 after 100 DRAIN cycles, plus layer_done; next accept clears timeout_err.
REQ-036 Early last: dp_last pulsed during STREAM at beat 500 -> DRAIN exits on its first cycle; layer_done with timeout_err=0.
REQ-037 Reset mid-stream at beat 300 -> next cycle all outputs 0, no layer_done; a new 32/14/14 layer afterwards completes normally with 784 beats.

Source files
------------

// File: rtl/conv_output_scheduler.sv
// Layer scheduler for the conv-output datapath: accepts a layer descriptor, pulses dp_start,
// forwards exactly total_beats activation beats, then waits for dp_last (bounded by TIMEOUT).
module conv_output_scheduler #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [15:0]       cfg_in_channel,
  input  logic [7:0]        cfg_matrix_col,
  input  logic [7:0]        cfg_matrix_row,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              dp_valid,
  input  logic              dp_ready,
  output logic [DATA_W-1:0] dp_data,
  output logic              dp_start,
  output logic [15:0]       dp_in_channel,
  output logic [7:0]        dp_matrix_col,
  output logic [7:0]        dp_matrix_row,
  input  logic              dp_last,
  output logic              busy,
  output logic              layer_done,
  output logic              timeout_err,
  output logic [2:0]        state_dbg
);

  // Handshake rule for cfg, s and dp: a transfer happens on a rising clk edge where
  // valid and ready are both high; valid never waits on ready.

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int          BYTES_PER_BEAT = DATA_W / 8;
  localparam logic [31:0] BPB_W          = 32'(BYTES_PER_BEAT);
  localparam logic [31:0] TIMEOUT_LAST   = 32'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] total_beats;
  logic [31:0] beat_cnt;
  logic [31:0] timeout_cnt;
  logic        last_seen;

  logic [31:0] cfg_bytes;
  logic [31:0] cfg_beats;
  logic        cfg_fire;
  logic        dp_fire;
  logic        streaming;

  // Ceiling division without widening the 32-bit product.
  assign cfg_bytes = 32'(cfg_in_channel) * 32'(cfg_matrix_col) * 32'(cfg_matrix_row);
  assign cfg_beats = (cfg_bytes / BPB_W) + {31'd0, ((cfg_bytes % BPB_W) != 32'd0)};

  assign streaming = (state == ST_STREAM);
  assign s_ready   = streaming & dp_ready;
  assign dp_valid  = streaming & s_valid;
  assign dp_data   = streaming ? s_data : '0;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign dp_fire   = dp_valid & dp_ready;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cfg_ready     <= 1'b0;
      dp_start      <= 1'b0;
      layer_done    <= 1'b0;
      timeout_err   <= 1'b0;
      last_seen     <= 1'b0;
      total_beats   <= '0;
      beat_cnt      <= '0;
      timeout_cnt   <= '0;
      dp_in_channel <= '0;
      dp_matrix_col <= '0;
      dp_matrix_row <= '0;
    end else begin
      dp_start   <= 1'b0;
      layer_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_fire) begin
            dp_in_channel <= cfg_in_channel;
            dp_matrix_col <= cfg_matrix_col;
            dp_matrix_row <= cfg_matrix_row;
            total_beats   <= cfg_beats;
            beat_cnt      <= '0;
            timeout_cnt   <= '0;
            last_seen     <= 1'b0;
            timeout_err   <= 1'b0;
            cfg_ready     <= 1'b0;
            if (cfg_beats == 32'd0) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_ARM;
              dp_start <= 1'b1;
            end
          end else begin
            cfg_ready <= 1'b1;
          end
        end
        ST_ARM: begin
          if (dp_last) last_seen <= 1'b1;
          state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (dp_last) last_seen <= 1'b1;
          if (dp_fire) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (beat_cnt == total_beats - 32'd1) begin
              state       <= ST_DRAIN;
              timeout_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          // A dp_last in the same cycle as expiry takes priority over the error.
          if (last_seen || dp_last) begin
            state <= ST_DONE;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_DONE;
          end else begin
            timeout_cnt <= timeout_cnt + 32'd1;
          end
        end
        ST_DONE: begin
          layer_done <= 1'b1;
          cfg_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_output_scheduler.sv
// Directed bench for conv_output_scheduler: nominal, backpressure, zero size, timeout,
// early dp_last and mid-stream reset, with a data scoreboard on the dp stream.
module tb_conv_output_scheduler;

  localparam int DW = 64;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [15:0]   cfg_in_channel = '0;
  logic [7:0]    cfg_matrix_col = '0;
  logic [7:0]    cfg_matrix_row = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          dp_valid;
  logic          dp_ready = 1'b0;
  logic [DW-1:0] dp_data;
  logic          dp_start;
  logic [15:0]   dp_in_channel;
  logic [7:0]    dp_matrix_col;
  logic [7:0]    dp_matrix_row;
  logic          dp_last = 1'b0;
  logic          busy;
  logic          layer_done;
  logic          timeout_err;
  logic [2:0]    state_dbg;

  conv_output_scheduler #(.DATA_W(DW), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_in_channel(cfg_in_channel), .cfg_matrix_col(cfg_matrix_col),
    .cfg_matrix_row(cfg_matrix_row),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data),
    .dp_start(dp_start), .dp_in_channel(dp_in_channel),
    .dp_matrix_col(dp_matrix_col), .dp_matrix_row(dp_matrix_row),
    .dp_last(dp_last), .busy(busy), .layer_done(layer_done),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int layer, input int i);
    return {32'(layer) ^ 32'h5A5A_0000, 32'(i) * 32'h9E37_79B9};
  endfunction

  // driver tasks
  task automatic accept(input logic [15:0] ch, input logic [7:0] c, input logic [7:0] r);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_in_channel = ch;
    cfg_matrix_col = c;
    cfg_matrix_row = r;
    #1;
    chk("cfg_ready_idle", cfg_ready, 1);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    s_valid = 1'b1;
    s_data = 64'hDEAD_BEEF_0000_0001;
    dp_ready = 1'b1;
    #1;
  endtask

  task automatic check_arm(input logic [15:0] ch, input logic [7:0] c, input logic [7:0] r);
    chk("arm_state", state_dbg, S_ARM);
    chk("arm_dp_start", dp_start, 1);
    chk("arm_busy", busy, 1);
    chk("arm_dp_valid", dp_valid, 0);
    chk("arm_s_ready", s_ready, 0);
    chk("arm_dp_data", dp_data, 0);
    chk("arm_cfg_ready", cfg_ready, 0);
    chk("arm_in_channel", dp_in_channel, ch);
    chk("arm_col", dp_matrix_col, c);
    chk("arm_row", dp_matrix_row, r);
    chk("arm_timeout_err", timeout_err, 0);
  endtask

  task automatic run_stream(input int n, input int pv, input int pr, input int last_at,
                            input int stop_at, input int layer, output int got);
    int cyc;
    bit pulsed;
    cyc = 0;
    pulsed = 1'b0;
    got = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(pat(layer, i));
    while (got < n && got != stop_at && cyc < 20000) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 99) < pv);
      s_data = pat(layer, got);
      dp_ready = ($urandom_range(0, 99) < pr);
      dp_last = (got == last_at) && !pulsed;
      if (dp_last) pulsed = 1'b1;
      #1;
      chk("stream_state", state_dbg, S_STREAM);
      chk("s_ready_mirror", s_ready, dp_ready);
      chk("dp_valid_mirror", dp_valid, s_valid);
      chk("stream_cfg_ready", cfg_ready, 0);
      chk("stream_dp_start", dp_start, 0);
      if (s_valid && dp_ready) begin
        chk("dp_data", dp_data, exp_q.pop_front());
        got++;
      end
      cyc++;
    end
    dp_last = 1'b0;
  endtask

  task automatic finish_layer(input bit give_last);
    @(negedge clk);
    cfg_valid = 1'b0;
    s_valid = 1'b1;
    dp_ready = 1'b1;
    dp_last = give_last;
    #1;
    chk("drain_state", state_dbg, S_DRAIN);
    chk("drain_dp_valid", dp_valid, 0);
    chk("drain_s_ready", s_ready, 0);
    chk("drain_dp_data", dp_data, 0);
    @(negedge clk);
    dp_last = 1'b0;
    #1;
    chk("done_state", state_dbg, S_DONE);
    chk("done_layer_done", layer_done, 0);
    @(negedge clk);
    #1;
    chk("layer_done_pulse", layer_done, 1);
    chk("after_state", state_dbg, S_IDLE);
    chk("after_busy", busy, 0);
    chk("after_timeout_err", timeout_err, 0);
    chk("after_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    #1;
    chk("layer_done_one_cycle", layer_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int d;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_cfg_ready", cfg_ready, 1);

    // nominal 32/14/14, descriptors offered mid-layer must be ignored
    accept(16'd32, 8'd14, 8'd14);
    check_arm(16'd32, 8'd14, 8'd14);
    cfg_valid = 1'b1;
    cfg_in_channel = 16'd7;
    cfg_matrix_col = 8'd3;
    cfg_matrix_row = 8'd2;
    run_stream(784, 100, 100, -1, -1, 1, got);
    chk("nominal_beats", got, 784);
    finish_layer(1'b1);
    chk("hold_in_channel", dp_in_channel, 32);
    chk("hold_col", dp_matrix_col, 14);
    chk("hold_row", dp_matrix_row, 14);

    // backpressure
    accept(16'd32, 8'd14, 8'd14);
    check_arm(16'd32, 8'd14, 8'd14);
    run_stream(784, 70, 50, -1, -1, 2, got);
    chk("bp_beats", got, 784);
    chk("bp_queue_empty", exp_q.size(), 0);
    finish_layer(1'b1);

    // zero-size layer
    accept(16'd32, 8'd0, 8'd14);
    chk("zero_state", state_dbg, S_DONE);
    chk("zero_dp_start", dp_start, 0);
    chk("zero_layer_done_early", layer_done, 0);
    chk("zero_dp_valid", dp_valid, 0);
    chk("zero_col", dp_matrix_col, 0);
    @(negedge clk);
    #1;
    chk("zero_layer_done", layer_done, 1);
    chk("zero_dp_start_late", dp_start, 0);
    chk("zero_idle", state_dbg, S_IDLE);
    @(negedge clk);
    #1;
    chk("zero_layer_done_one", layer_done, 0);

    // ceiling to one beat, then timeout with no dp_last
    accept(16'd3, 8'd1, 8'd1);
    check_arm(16'd3, 8'd1, 8'd1);
    run_stream(1, 100, 100, -1, -1, 3, got);
    chk("ceil_beats", got, 1);
    d = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (state_dbg != S_DRAIN) break;
      chk("drain_no_err", timeout_err, 0);
      chk("drain_no_beat", dp_valid, 0);
      d++;
    end
    chk("drain_cycles", d, 100);
    chk("to_state_done", state_dbg, S_DONE);
    chk("to_err_set", timeout_err, 1);
    chk("to_layer_done_early", layer_done, 0);
    @(negedge clk);
    #1;
    chk("to_layer_done", layer_done, 1);
    chk("to_err_sticky", timeout_err, 1);
    @(negedge clk);
    #1;
    chk("to_err_sticky_idle", timeout_err, 1);
    chk("to_layer_done_one", layer_done, 0);

    // early dp_last at beat 500; accept also clears timeout_err
    accept(16'd32, 8'd14, 8'd14);
    check_arm(16'd32, 8'd14, 8'd14);
    run_stream(784, 100, 100, 500, -1, 5, got);
    chk("early_beats", got, 784);
    finish_layer(1'b0);

    // reset mid-stream at beat 300
    accept(16'd32, 8'd14, 8'd14);
    check_arm(16'd32, 8'd14, 8'd14);
    run_stream(784, 80, 80, -1, 300, 6, got);
    chk("rst_mid_beats", got, 300);
    @(negedge clk);
    reset = 1'b0;
    s_valid = 1'b0;
    dp_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = pat(6, 300);
    #1;
    chk("mid_rst_state", state_dbg, S_IDLE);
    chk("mid_rst_dp_valid", dp_valid, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_dp_data", dp_data, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_layer_done", layer_done, 0);
    chk("mid_rst_timeout_err", timeout_err, 0);
    chk("mid_rst_dp_start", dp_start, 0);
    chk("mid_rst_in_channel", dp_in_channel, 0);
    reset = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rel_cfg_ready", cfg_ready, 1);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("mid_rel_no_done", layer_done, 0);
      chk("mid_rel_no_beat", dp_valid, 0);
    end
    accept(16'd32, 8'd14, 8'd14);
    check_arm(16'd32, 8'd14, 8'd14);
    run_stream(784, 100, 100, -1, -1, 7, got);
    chk("post_rst_beats", got, 784);
    finish_layer(1'b1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
